// File: rtl/lm_sm_pkg.sv
// Shared types and constants for the LM/SM register-side sequencer.
package lm_sm_pkg;

   localparam int DATA_W = 16;
   localparam int NREG   = 8;
   localparam int IDX_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   // Index of the lowest set bit; bit 0 has priority so registers are
   // visited in the same ascending order as the address generator.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [NREG-1:0] m);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (m[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/lm_sm_lat_pipe.sv
// MEM_LAT-deep valid+index shift register that lines up each LM beat's
// destination register with its returning memory data.
module lm_sm_lat_pipe #(
   parameter int MEM_LAT = 1,
   parameter int IDX_W   = 3
) (
   input  logic             clk,
   input  logic             flush,
   input  logic             push_vld,
   input  logic [IDX_W-1:0] push_idx,
   output logic             pop_vld,
   output logic [IDX_W-1:0] pop_idx,
   output logic             pending
);
   import lm_sm_pkg::*;

   logic [MEM_LAT-1:0] vld_p;
   logic [IDX_W-1:0]   idx_p [MEM_LAT];

   // Valid bits: cleared by flush, otherwise advance one stage per cycle.
   always_ff @(posedge clk) begin
      if (flush) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= push_vld;
         for (int i = 1; i < MEM_LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   // Index payload shifts freely; it is only meaningful where valid is set.
   always_ff @(posedge clk) begin
      idx_p[0] <= push_idx;
      for (int i = 1; i < MEM_LAT; i++) idx_p[i] <= idx_p[i-1];
   end

   // Entries still in flight behind the output stage.
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < MEM_LAT - 1; i++) pending = pending | vld_p[i];
   end

   assign pop_vld = vld_p[MEM_LAT-1];
   assign pop_idx = idx_p[MEM_LAT-1];

endmodule

// File: rtl/lm_sm_reg_sequencer.sv
// Register-file side of the LM/SM micro-sequence: walks the register mask
// one beat per cycle, drives SM write data directly and retires LM loads
// MEM_LAT cycles after each beat.
module lm_sm_reg_sequencer #(
   parameter int DATA_W  = 16,
   parameter int NREG    = 8,
   parameter int IDX_W   = 3,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              is_load,
   input  logic [NREG-1:0]   mask,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              addr_adv,
   output logic [IDX_W-1:0]  rf_raddr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              rf_we,
   output logic [IDX_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              stall,
   output logic              busy,
   output logic              done
);
   import lm_sm_pkg::*;

   state_t            state_q, state_d;
   logic [NREG-1:0]   rem_q, rem_d;
   logic              mode_q, mode_d;
   logic [IDX_W-1:0]  idx;
   logic              push_vld;
   logic              pop_vld;
   logic [IDX_W-1:0]  pop_idx;
   logic              pending;

   assign idx = IDX_W'(lowest_set(rem_q));

   // Control state: FSM, remaining-register mask and LM/SM mode.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state and beat outputs; everything idles at zero by default.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      mode_d    = mode_q;
      addr_adv  = 1'b0;
      rf_raddr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      push_vld  = 1'b0;
      stall     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (mask != '0) begin
                  rem_d   = mask;
                  mode_d  = is_load;
                  state_d = RUN;
               end else begin
                  state_d = FIN;
               end
            end
         end
         RUN: begin
            stall    = 1'b1;
            busy     = 1'b1;
            addr_adv = 1'b1;
            rem_d    = rem_q & ~(NREG'(1) << idx);
            if (mode_q) begin
               push_vld = 1'b1;
            end else begin
               rf_raddr  = idx;
               mem_we    = 1'b1;
               mem_wdata = rf_rdata;
            end
            if (rem_d == '0) state_d = mode_q ? DRAIN : FIN;
         end
         DRAIN: begin
            stall = 1'b1;
            busy  = 1'b1;
            if (!pending) state_d = FIN;
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   lm_sm_lat_pipe #(
      .MEM_LAT (MEM_LAT),
      .IDX_W   (IDX_W)
   ) u_lat_pipe (
      .clk      (clk),
      .flush    (!reset_n),
      .push_vld (push_vld),
      .push_idx (idx),
      .pop_vld  (pop_vld),
      .pop_idx  (pop_idx),
      .pending  (pending)
   );

   // LM writeback is independent of the FSM: any valid pipe output retires.
   always_comb begin
      rf_we    = pop_vld;
      rf_waddr = pop_vld ? pop_idx : '0;
      rf_wdata = pop_vld ? mem_rdata : '0;
   end

endmodule

// File: doc/lm_sm_reg_sequencer.md
Name: lm_sm_reg_sequencer

Overview:
- Register-file side of the LM/SM (load/store multiple) micro-sequence; runs in lockstep with the multiple-transfer memory address generator.
- On each beat it picks the next register from the 8-bit register mask and tells the address generator to advance.
- For LM it writes the returning memory data into that register. For SM it reads that register and drives the memory write data.
- While the sequence runs it stalls the upstream pipeline, then pulses done.

Parameters:
DATA_W, 16, width of register and memory data
NREG, 8, number of architectural registers (mask width)
IDX_W, 3, register index width (clog2 of NREG)
MEM_LAT, 1, memory read latency in cycles, from addr_adv beat to valid mem_rdata (legal values 1..3)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse from decode/EX when an LM/SM reaches the memory stage
is_load  in  1  sampled with start; 1 = LM, 0 = SM
mask  in  NREG  sampled with start; IW[7:0] register list, bit i = Ri
mem_rdata  in  DATA_W  memory read data (LM)
rf_rdata  in  DATA_W  register-file read data, combinational from rf_raddr (SM)
addr_adv  out  1  beat strobe to the address generator: consume one mask bit, index+1
rf_raddr  out  IDX_W  register-file read index (SM)
mem_we  out  1  memory write enable (SM)
mem_wdata  out  DATA_W  memory write data (SM)
rf_we  out  1  register-file write enable (LM)
rf_waddr  out  IDX_W  register-file write index (LM)
rf_wdata  out  DATA_W  register-file write data (LM)
stall  out  1  freeze the upstream pipeline stages
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Clock, reset and outputs
  - All state updates on the rising edge of clk. Reset is synchronous and active-low on reset_n.
  - Reset values: every output is 0. State goes to IDLE, the latched mask is cleared, and the latency pipe is flushed (no valid entries).
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE
  - start=1, mask!=0: latch mask into rem and is_load into mode; go to RUN.
  - start=1, mask==0: go directly to FIN. No beats are issued and no stall is raised.
- RUN, once per cycle:
  - idx = lowest set bit of rem (priority encoder, bit 0 first), matching the address generator's base+k ordering.
  - addr_adv=1. Clear bit idx in rem.
  - SM: rf_raddr=idx, mem_we=1, mem_wdata=rf_rdata, all in the same cycle (combinational from state).
  - LM: push {valid, idx} into a MEM_LAT-deep shift pipe. rf_raddr, mem_we and mem_wdata stay 0.
  - When the bit cleared is the last one in rem: LM goes to DRAIN; SM goes to FIN.
- DRAIN: no beats are issued; the pipe keeps shifting. Go to FIN once the last entry has popped out.
- LM writeback, any state: when the pipe output is valid, drive rf_we=1, rf_waddr=pipe idx, rf_wdata=mem_rdata in that cycle.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- stall and busy are 1 in RUN and DRAIN, and 0 in IDLE and FIN.
- Latency
  - Beat count = popcount(mask).
  - First addr_adv is 1 cycle after start.
  - For LM, rf_we for beat k occurs MEM_LAT cycles after that beat's addr_adv.
- Boundary conditions
  - start while not IDLE is ignored. mask and is_load are not resampled.
  - mask=0xFF gives 8 consecutive beats with no bubbles.
  - A single set bit gives one beat; a DRAIN of length MEM_LAT still applies for LM.
  - reset_n=0 mid-sequence: reset values apply on the next edge, so no further rf_we or mem_we, the pipe is discarded, and done does not fire.
  - The pipe output and a new beat may coincide in the same cycle; they are independent.

Decomposition:
- Shared package lm_sm_pkg:
  - state enum {IDLE, RUN, DRAIN, FIN}
  - DATA_W, NREG, IDX_W constants
  - function lowest_set(mask) returning an index
- One sub-module, lm_sm_lat_pipe: a parameterised MEM_LAT-deep valid+index shift register with synchronous flush.

Test Plan:
1. LM, mask=8'b1010_0101, MEM_LAT=1 -> beats on cycles 1..4 after start. rf_we on cycles 2..5 with rf_waddr 0, 2, 5, 7 and rf_wdata = mem_rdata of each. done at cycle 6. stall high on cycles 1..5.
2. SM, mask=8'hFF -> 8 consecutive cycles with mem_we=1 and rf_raddr 0..7, mem_wdata=rf_rdata. No rf_we. done 1 cycle after the last beat.
3. start with mask=8'h00 -> no addr_adv, stall stays 0, done pulses exactly once, 1 cycle after start.
4. LM, mask=8'h80, MEM_LAT=3 -> single beat with rf_waddr=7 three cycles after it. stall is held through DRAIN.
5. LM, mask=8'hF0, reset_n=0 after the 2nd beat -> all outputs 0 next cycle. No pending rf_we emerges. No done pulse. FSM is in IDLE.
6. Second start pulse during RUN, with a different mask -> ignored. The original beat sequence and done timing are unchanged.
